// File: rtl/result_tx_seq_if.sv
// Bundle between the FPU result path, the UART byte transmitter and status logic.
// The sequencer takes the slave view; whoever drives results and the UART busy flag takes the master view.
interface result_tx_seq_if;
    logic [31:0] result;
    logic        res_valid;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        frame_done;
    logic        busy;
    logic        overflow;
    logic [4:0]  fifo_count;

    modport slave (
        input  result, res_valid, tx_busy,
        output tx_start, tx_data, frame_done, busy, overflow, fifo_count
    );

    modport master (
        output result, res_valid, tx_busy,
        input  tx_start, tx_data, frame_done, busy, overflow, fifo_count
    );
endinterface

// File: rtl/result_tx_seq.sv
// Buffers 32-bit FPU results in a small FIFO and streams each one to a UART
// transmitter as four bytes, MSB first, with a busy-rise timeout per byte.
module result_tx_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int BUSY_TO    = 16
) (
    input  logic           clk,
    input  logic           rst,
    result_tx_seq_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(BUSY_TO + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TO - 1);
    localparam logic [4:0]    FULL_CNT = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]      count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     shift_q, shift_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [TW-1:0]   to_q, to_d;

    logic            empty_s, full_s, pop_s, push_s, drop_s;
    logic            tx_start_s, frame_done_s;

    // FIFO control: a pop from IDLE frees a slot, so a push into a full FIFO is accepted in that cycle
    always_comb begin
        empty_s    = (count_q == 5'd0);
        full_s     = (count_q == FULL_CNT);
        pop_s      = (state_q == IDLE) && !empty_s && !rst;
        push_s     = bus.res_valid && (!full_s || pop_s) && !rst;
        drop_s     = bus.res_valid && full_s && !pop_s && !rst;
        wr_ptr_d   = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        overflow_d = overflow_q | drop_s;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.result;
        end
    end

    // Next-state and byte datapath for the transmit sequencer
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        to_d       = to_q;
        case (state_q)
            IDLE: begin
                if (pop_s) begin
                    shift_d    = mem_q[rd_ptr_q];
                    byte_idx_d = 2'd0;
                    state_d    = START;
                end else begin
                    state_d    = IDLE;
                end
            end
            START: begin
                if (!bus.tx_busy) begin
                    to_d    = '0;
                    state_d = WAIT_HI;
                end else begin
                    state_d = START;
                end
            end
            WAIT_HI: begin
                // A transmitter that never raises busy must not stall the frame forever
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else if (to_q == TO_LAST) begin
                    state_d = WAIT_LO;
                end else begin
                    to_d    = to_q + TW'(1);
                end
            end
            WAIT_LO: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else if (byte_idx_q == 2'd3) begin
                    state_d = IDLE;
                end else begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    shift_d    = {shift_q[23:0], 8'h00};
                    state_d    = START;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO pointers, status and byte datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
            shift_q    <= 32'h0000_0000;
            byte_idx_q <= 2'd0;
            to_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            to_q       <= to_d;
        end
    end

    // Handshake pulses decoded from state and the live busy flag
    always_comb begin
        tx_start_s   = 1'b0;
        frame_done_s = 1'b0;
        case (state_q)
            START:   tx_start_s   = !bus.tx_busy;
            WAIT_LO: frame_done_s = !bus.tx_busy && (byte_idx_q == 2'd3);
            default: begin
                tx_start_s   = 1'b0;
                frame_done_s = 1'b0;
            end
        endcase
    end

    // Outputs are held quiet for the whole reset cycle, not only after it
    assign bus.tx_start   = tx_start_s & ~rst;
    assign bus.frame_done = frame_done_s & ~rst;
    assign bus.busy       = ~rst & (~empty_s | (state_q != IDLE));
    assign bus.overflow   = overflow_q & ~rst;
    assign bus.tx_data    = rst ? 8'h00 : shift_q[31:24];
    assign bus.fifo_count = rst ? 5'd0 : count_q;
endmodule

// File: tb/tb_result_tx_seq.sv
// Directed bench for result_tx_seq: a per-cycle vector table for reset, latency and
// byte sequencing, then hand-written multi-cycle scenarios with a UART busy model.
module tb_result_tx_seq;
    logic clk;
    logic rst;

    result_tx_seq_if bus ();

    result_tx_seq #(.FIFO_DEPTH(4), .BUSY_TO(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] res;
        logic        txb;
        logic        e_start;
        logic [7:0]  e_data;
        logic        e_fd;
        logic        e_busy;
        logic        e_ov;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t     vt [20];
    int       n_chk = 0;
    int       n_fail = 0;
    int       n_fd = 0;
    int       cyc = 0;
    int       mode = 0;
    int       bcnt = 0;
    logic     last_start = 1'b0;
    logic [7:0]  obs_bytes [$];
    int          start_cyc [$];
    logic [7:0]  exp_bytes [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample outputs at negedge, then advance to just after the next rising edge
    task automatic cycle();
        @(negedge clk);
        last_start = bus.tx_start;
        if (bus.tx_start) begin
            obs_bytes.push_back(bus.tx_data);
            start_cyc.push_back(cyc);
        end
        if (bus.frame_done) n_fd++;
        @(posedge clk);
        #1;
        cyc++;
        bus.res_valid = 1'b0;
        case (mode)
            0: bus.tx_busy = 1'b0;
            1: begin
                if (last_start) bcnt = 10;
                bus.tx_busy = (bcnt != 0);
                if (bcnt != 0) bcnt--;
            end
            default: bus.tx_busy = 1'b1;
        endcase
    endtask

    task automatic run_until(input int target, input int budget);
        for (int k = 0; k < budget && n_fd < target; k++) cycle();
        chk("frame_done_count", n_fd, target);
    endtask

    task automatic wait_starts(input int target, input int budget);
        for (int k = 0; k < budget && obs_bytes.size() < target; k++) cycle();
        chk("tx_start_count", obs_bytes.size(), target);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.res_valid = 1'b0;
        bus.tx_busy = 1'b0;
        mode = 0;
        bcnt = 0;
        cycle();
        rst = 1'b0;
        obs_bytes.delete();
        start_cyc.delete();
        exp_bytes.delete();
        n_fd = 0;
    endtask

    task automatic push(input logic [31:0] w);
        bus.result = w;
        bus.res_valid = 1'b1;
        cycle();
    endtask

    task automatic expect_word(input logic [31:0] w);
        exp_bytes.push_back(w[31:24]);
        exp_bytes.push_back(w[23:16]);
        exp_bytes.push_back(w[15:8]);
        exp_bytes.push_back(w[7:0]);
    endtask

    task automatic chk_bytes(input string name);
        chk({name, "_nbytes"}, obs_bytes.size(), exp_bytes.size());
        for (int i = 0; i < obs_bytes.size() && i < exp_bytes.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), {24'h0, obs_bytes[i]}, {24'h0, exp_bytes[i]});
    endtask

    function automatic logic [31:0] word_k(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {8'h10 + b, 8'h20 + b, 8'h30 + b, 8'h40 + b};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nsb;
        //          rst   rv    res            txb   start data   fd    busy  ov    cnt
        vt[0]  = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
        vt[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
        vt[2]  = '{1'b0, 1'b1, 32'hA1B2C3D4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
        vt[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd1};
        vt[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 8'hD4, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'hD4, 1'b0, 1'b1, 1'b0, 5'd0};
        vt[18] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 8'hD4, 1'b1, 1'b1, 1'b0, 5'd0};
        vt[19] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 8'hD4, 1'b0, 1'b0, 1'b0, 5'd0};

        rst = 1'b1;
        bus.res_valid = 1'b0;
        bus.result = 32'h0;
        bus.tx_busy = 1'b0;
        @(posedge clk);
        #1;

        // Per-cycle table: reset, 2-cycle latency, busy-held START, MSB-first bytes, frame_done
        for (int i = 0; i < 20; i++) begin
            rst = vt[i].rst;
            bus.res_valid = vt[i].rv;
            bus.result = vt[i].res;
            bus.tx_busy = vt[i].txb;
            @(negedge clk);
            chk($sformatf("v%0d_tx_start", i), {31'h0, bus.tx_start}, {31'h0, vt[i].e_start});
            chk($sformatf("v%0d_tx_data", i), {24'h0, bus.tx_data}, {24'h0, vt[i].e_data});
            chk($sformatf("v%0d_frame_done", i), {31'h0, bus.frame_done}, {31'h0, vt[i].e_fd});
            chk($sformatf("v%0d_busy", i), {31'h0, bus.busy}, {31'h0, vt[i].e_busy});
            chk($sformatf("v%0d_overflow", i), {31'h0, bus.overflow}, {31'h0, vt[i].e_ov});
            chk($sformatf("v%0d_fifo_count", i), {27'h0, bus.fifo_count}, {27'h0, vt[i].e_cnt});
            @(posedge clk);
            #1;
        end
        bus.res_valid = 1'b0;

        // Single result with a 10-cycle busy pulse per byte
        do_reset();
        mode = 1;
        push(32'h40490FDB);
        run_until(1, 300);
        expect_word(32'h40490FDB);
        chk_bytes("pi");
        chk("pi_busy_after", {31'h0, bus.busy}, 32'h0);
        for (int k = 0; k < 10; k++) cycle();
        chk("pi_single_frame_done", n_fd, 1);

        // tx_busy tied low: each byte waits out the 16-cycle timeout
        do_reset();
        mode = 0;
        push(32'h12345678);
        run_until(1, 300);
        expect_word(32'h12345678);
        chk_bytes("timeout");
        for (int i = 0; i + 1 < start_cyc.size(); i++)
            chk($sformatf("timeout_gap%0d", i), start_cyc[i + 1] - start_cyc[i], 18);

        // Six pushes with busy held high: one popped, four queued, sixth dropped
        do_reset();
        mode = 2;
        bus.tx_busy = 1'b1;
        for (int k = 0; k < 6; k++) push(word_k(k));
        chk("ovf_fifo_count", {27'h0, bus.fifo_count}, 32'd4);
        chk("ovf_flag", {31'h0, bus.overflow}, 32'h1);
        chk("ovf_no_start_while_busy", obs_bytes.size(), 0);
        mode = 1;
        bus.tx_busy = 1'b0;
        run_until(5, 1000);
        for (int k = 0; k < 5; k++) expect_word(word_k(k));
        chk_bytes("ovf_order");
        for (int k = 0; k < 20; k++) cycle();
        chk("ovf_no_sixth_frame", n_fd, 5);
        chk("ovf_sticky", {31'h0, bus.overflow}, 32'h1);

        // Push coincident with a pop while full: accepted, no overflow, order kept
        do_reset();
        mode = 2;
        bus.tx_busy = 1'b1;
        for (int k = 0; k < 5; k++) push(word_k(k));
        chk("full_fifo_count", {27'h0, bus.fifo_count}, 32'd4);
        chk("full_no_overflow", {31'h0, bus.overflow}, 32'h0);
        mode = 1;
        bus.tx_busy = 1'b0;
        run_until(1, 300);
        push(word_k(5));
        chk("pushpop_fifo_count", {27'h0, bus.fifo_count}, 32'd4);
        chk("pushpop_no_overflow", {31'h0, bus.overflow}, 32'h0);
        run_until(6, 1200);
        for (int k = 0; k < 6; k++) expect_word(word_k(k));
        chk_bytes("pushpop_order");

        // Reset after the second byte aborts the frame; next result starts at its MSB
        do_reset();
        mode = 1;
        push(32'hCAFEF00D);
        wait_starts(2, 200);
        for (int k = 0; k < 3; k++) cycle();
        rst = 1'b1;
        bus.result = 32'hDEADBEEF;
        bus.res_valid = 1'b1;
        @(negedge clk);
        chk("rst_tx_start", {31'h0, bus.tx_start}, 32'h0);
        chk("rst_frame_done", {31'h0, bus.frame_done}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.res_valid = 1'b0;
        bcnt = 0;
        bus.tx_busy = 1'b0;
        chk("post_rst_fifo_count", {27'h0, bus.fifo_count}, 32'd0);
        chk("post_rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("post_rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
        chk("post_rst_tx_start", {31'h0, bus.tx_start}, 32'h0);
        nsb = obs_bytes.size();
        for (int k = 0; k < 40; k++) cycle();
        chk("post_rst_no_start", obs_bytes.size(), nsb);
        chk("post_rst_no_frame_done", n_fd, 0);
        obs_bytes.delete();
        start_cyc.delete();
        push(32'h13579BDF);
        run_until(1, 300);
        expect_word(32'h13579BDF);
        chk_bytes("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
